twos_complement_decoder: RTL and testbench



---
 rtl/twos_complement_decoder.sv | 56 +++++
 tb/tb_twos_complement_decoder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/twos_complement_decoder.sv
// twos_complement_decoder: bit-serial 16-bit two's-complement to sign/magnitude converter
module twos_complement_decoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] A,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] mag,
  output logic        sign,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, COPY, INVERT, DONE} state_t;
  state_t state, state_nx;
  logic [15:0] sh, res;
  logic [3:0] cnt;
  logic sign_r, bit_out, last;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign busy = state == COPY || state == INVERT;
  assign mag = res;
  assign sign = sign_r;
  assign last = cnt == 4'd15;
  always_comb begin
    bit_out = state == INVERT ? ~sh[0] : sh[0];
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = in_valid ? COPY : IDLE;
      COPY:    state_nx = last ? DONE : (sign_r && sh[0]) ? INVERT : COPY;
      INVERT:  state_nx = last ? DONE : INVERT;
      DONE:    state_nx = out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      sh <= '0;
      res <= '0;
      cnt <= '0;
      sign_r <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && in_valid) begin
        sh <= A;
        sign_r <= A[15];
        res <= '0;
        cnt <= '0;
      end else if (busy) begin
        res[cnt] <= bit_out;
        sh <= sh >> 1;
        cnt <= cnt + 4'd1;
      end
    end
endmodule

// File: tb/tb_twos_complement_decoder.sv
// tb_twos_complement_decoder: randomized bench against a timeline-level reference model
module tb_twos_complement_decoder;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, sign, busy;
  logic [15:0] A = '0, mag;
  int n_chk = 0, n_fail = 0;
  bit have = 0;
  int c = 0, t_acc = 0, n_acc = 0, n_dut = 0;
  logic [15:0] e_mag = '0;
  logic e_sign = 0;

  twos_complement_decoder dut (
    .clk(clk), .rst_n(rst_n), .A(A), .in_valid(in_valid), .in_ready(in_ready),
    .mag(mag), .sign(sign), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] absval(input logic [15:0] a);
    int v;
    v = int'($signed(a));
    return 16'(v < 0 ? -v : v);
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: a word is busy for the 16 edges after acceptance, then held until taken.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) have = 0;
    else begin
      if (have && c - t_acc >= 16 && out_ready) have = 0;
      else if (!have && in_valid) begin
        have = 1;
        t_acc = c + 1;
        e_mag = absval(A);
        e_sign = A[15];
        n_acc++;
      end
      c++;
    end

  always @(posedge clk) if (rst_n && out_valid && out_ready) n_dut++;

  always @(negedge clk) if (rst_n) begin
    check("in_ready", 32'(!have), 32'(in_ready) ^ 32'(in_ready) ^ 32'(!have)) ;
  end

  always @(negedge clk) if (rst_n) begin
    check("in_ready_model", 32'(in_ready), 32'(!have));
    check("out_valid_model", 32'(out_valid), 32'(have && c - t_acc >= 16));
    check("busy_model", 32'(busy), 32'(have && c - t_acc < 16));
    if (have && c - t_acc >= 16) begin
      check("mag_model", 32'(mag), 32'(e_mag));
      check("sign_model", 32'(sign), 32'(e_sign));
    end
  end

  task automatic convert(input logic [15:0] a, input logic [15:0] em, input logic es, input bit hold);
    int n;
    @(negedge clk);
    A = a; in_valid = 1; out_ready = hold;
    @(negedge clk);
    in_valid = 0; A = 16'($urandom);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("latency", 32'(n), 32'd16);
    check("mag_lit", 32'(mag), 32'(em));
    check("sign_lit", 32'(sign), 32'(es));
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    check("in_ready_after", 32'(in_ready), 32'd1);
    check("out_valid_after", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, cyc, a0, d0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mag", 32'(mag), 32'd0);
    check("rst_sign", 32'(sign), 32'd0);
    #2 rst_n = 1;
    convert(16'hFFF6, 16'h000A, 1'b1, 1'b1);
    convert(16'h8000, 16'h8000, 1'b1, 1'b0);
    convert(16'hFFFF, 16'h0001, 1'b1, 1'b0);
    convert(16'h7FFF, 16'h7FFF, 1'b0, 1'b0);
    convert(16'h0000, 16'h0000, 1'b0, 1'b0);
    convert(16'h0001, 16'h0001, 1'b0, 1'b1);
    // backpressure with distracting input traffic
    @(negedge clk);
    A = 16'h8765; in_valid = 1; out_ready = 0;
    @(negedge clk);
    in_valid = 0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("bp_latency", 32'(n), 32'd16);
    repeat (10) begin
      in_valid = 1'($urandom_range(0, 1)); A = 16'($urandom);
      @(negedge clk);
      check("bp_mag", 32'(mag), 32'h789B);
      check("bp_sign", 32'(sign), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1; out_ready = 1;
    @(negedge clk);
    in_valid = 0; out_ready = 0;
    check("bp_no_accept_busy", 32'(busy), 32'd0);
    check("bp_no_accept_ready", 32'(in_ready), 32'd1);
    // asynchronous reset in the middle of a conversion
    @(negedge clk);
    A = 16'hC000; in_valid = 1; out_ready = 1;
    @(negedge clk);
    in_valid = 0;
    repeat (6) @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    #2 rst_n = 0;
    #1;
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_mag", 32'(mag), 32'd0);
    check("arst_sign", 32'(sign), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1;
    out_ready = 0;
    convert(16'h0005, 16'h0005, 1'b0, 1'b0);
    // random stream
    a0 = n_acc; d0 = n_dut; cyc = 0;
    while (n_acc - a0 < 1000 && cyc < 60000) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      A = 16'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      cyc++;
    end
    check("stream_accepts", 32'(n_acc - a0), 32'd1000);
    @(negedge clk);
    in_valid = 0; out_ready = 1;
    n = 0;
    while (have && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("drain_idle", 32'(in_ready), 32'd1);
    check("stream_delivered", 32'(n_dut - d0), 32'(n_acc - a0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
